// File: rtl/router_pkg.sv
// Shared mesh-router definitions: direction indices, header bit layout and the
// one-hot direction vector type used between input and output controllers.
package router_pkg;

    localparam int DIR_PE = 0;
    localparam int DIR_S  = 1;
    localparam int DIR_N  = 2;
    localparam int DIR_E  = 3;
    localparam int DIR_W  = 4;

    localparam int VC_BIT   = 63;
    localparam int XDIR_BIT = 62;
    localparam int YDIR_BIT = 61;
    localparam int HOPX_MSB = 55;
    localparam int HOPX_LSB = 52;
    localparam int HOPY_MSB = 51;
    localparam int HOPY_LSB = 48;

    typedef logic [4:0] dir_t;

endpackage

// File: rtl/xy_route.sv
// XY dimension-order route computation: picks the output direction for a packet
// and returns the header with the consumed hop count decremented.
module xy_route
    import router_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int HOP_W  = 4
) (
    input  logic [DATA_W-1:0] pkt_in,
    output dir_t              route,
    output logic [DATA_W-1:0] pkt_out
);

    logic [HOP_W-1:0] hop_x;
    logic [HOP_W-1:0] hop_y;

    assign hop_x = pkt_in[HOPX_LSB +: HOP_W];
    assign hop_y = pkt_in[HOPY_LSB +: HOP_W];

    // X is exhausted first; decrements only touch a nonzero field so they never wrap.
    always_comb begin
        pkt_out = pkt_in;
        route   = '0;
        if (hop_x != '0) begin
            if (pkt_in[XDIR_BIT]) route[DIR_W] = 1'b1;
            else                  route[DIR_E] = 1'b1;
            pkt_out[HOPX_LSB +: HOP_W] = hop_x - 1'b1;
        end else if (hop_y != '0) begin
            if (pkt_in[YDIR_BIT]) route[DIR_S] = 1'b1;
            else                  route[DIR_N] = 1'b1;
            pkt_out[HOPY_LSB +: HOP_W] = hop_y - 1'b1;
        end else begin
            route[DIR_PE] = 1'b1;
        end
    end

endmodule

// File: rtl/input_ctrl.sv
// Per-port router input stage: two virtual-channel buffers alternating between a
// link-side (writable) phase and an internal (requesting) phase under polarity.
module input_ctrl
    import router_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int HOP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              polarity,
    input  logic              send_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready_in,
    output dir_t              req,
    output logic [DATA_W-1:0] data_out,
    input  dir_t              clear_in
);

    logic [DATA_W-1:0] buf_q   [2];
    dir_t              route_q [2];
    logic [1:0]        valid_q;

    logic              wr_idx;
    logic              rd_idx;
    logic              wr_en;
    logic              clr_en;
    dir_t              rt_dir;
    logic [DATA_W-1:0] rt_pkt;
    logic [DATA_W-1:0] wr_pkt;

    assign wr_idx = ~polarity;
    assign rd_idx = polarity;

    xy_route #(
        .DATA_W (DATA_W),
        .HOP_W  (HOP_W)
    ) u_xy_route (
        .pkt_in  (data_in),
        .route   (rt_dir),
        .pkt_out (rt_pkt)
    );

    // The stored vc bit names the buffer the packet lives in.
    always_comb begin
        wr_pkt         = rt_pkt;
        wr_pkt[VC_BIT] = wr_idx;
    end

    assign ready_in = ~valid_q[wr_idx];
    assign wr_en    = send_in & ready_in;
    // Clears arrive the cycle after the grant, so they target the link-side buffer.
    assign clr_en   = valid_q[wr_idx] & (|(clear_in & route_q[wr_idx]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i]   <= '0;
                route_q[i] <= '0;
            end
        end else if (wr_en) begin
            buf_q[wr_idx]   <= wr_pkt;
            route_q[wr_idx] <= rt_dir;
            valid_q[wr_idx] <= 1'b1;
        end else if (clr_en) begin
            valid_q[wr_idx] <= 1'b0;
        end
    end

    assign req      = valid_q[rd_idx] ? route_q[rd_idx] : '0;
    assign data_out = valid_q[rd_idx] ? buf_q[rd_idx] : '0;

endmodule

// File: tb/tb_input_ctrl.sv
// Directed and randomized bench for input_ctrl against a per-VC packet model.
module tb_input_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        polarity;
    logic        send_in;
    logic [63:0] data_in;
    logic        ready_in;
    logic [4:0]  req;
    logic [63:0] data_out;
    logic [4:0]  clear_in;

    int n_total = 0;
    int n_pass  = 0;

    // Model: what each VC currently holds and where it wants to go.
    bit          m_valid [2];
    logic [63:0] m_data  [2];
    logic [4:0]  m_route [2];

    input_ctrl #(.DATA_W(64), .HOP_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .send_in  (send_in),
        .data_in  (data_in),
        .ready_in (ready_in),
        .req      (req),
        .data_out (data_out),
        .clear_in (clear_in)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input bit vc, input bit xd, input bit yd,
                                       input int hx, input int hy, input logic [31:0] pl);
        logic [63:0] p;
        p = {$urandom, $urandom};
        p[63] = vc; p[62] = xd; p[61] = yd;
        p[55:52] = 4'(hx); p[51:48] = 4'(hy);
        p[31:0] = pl;
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_data[i] = '0; m_route[i] = '0;
        end
    endtask

    // Stores a packet the way the router should: XY order, hop consumed, vc = buffer index.
    task automatic model_edge(input bit p, input bit s, input logic [63:0] d, input logic [4:0] c);
        int w, hx, hy;
        logic [63:0] h;
        w = p ? 0 : 1;
        if (s && !m_valid[w]) begin
            h = d; hx = int'(d[55:52]); hy = int'(d[51:48]);
            if (hx > 0) begin
                m_route[w] = d[62] ? 5'b10000 : 5'b01000;
                h[55:52] = 4'(hx - 1);
            end else if (hy > 0) begin
                m_route[w] = d[61] ? 5'b00010 : 5'b00100;
                h[51:48] = 4'(hy - 1);
            end else begin
                m_route[w] = 5'b00001;
            end
            h[63] = (w == 1);
            m_data[w]  = h;
            m_valid[w] = 1;
        end else if (m_valid[w] && ((c & m_route[w]) != 5'b0)) begin
            m_valid[w] = 0;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    task automatic check_outputs(input string tag);
        int r, w;
        r = polarity ? 1 : 0;
        w = 1 - r;
        check({tag, ".ready_in"}, 64'(ready_in), 64'(!m_valid[w]));
        check({tag, ".req"},      64'(req),      m_valid[r] ? 64'(m_route[r]) : 64'd0);
        check({tag, ".data_out"}, data_out,      m_valid[r] ? m_data[r] : 64'd0);
    endtask

    task automatic step(input string tag, input bit p, input bit s,
                        input logic [63:0] d, input logic [4:0] c);
        @(negedge clk);
        polarity = p; send_in = s; data_in = d; clear_in = c;
        #1;
        check_outputs(tag);
        @(posedge clk);
        model_edge(p, s, d, c);
    endtask

    initial begin
        logic [63:0] pkt;
        logic [4:0]  clr;
        bit          p;

        reset = 1'b1; polarity = 1'b0; send_in = 1'b0; data_in = '0; clear_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_outputs("reset");

        for (int i = 0; i < 4; i++) step("idle", i[0], 1'b0, '0, '0);

        // East packet into odd VC, then grant/clear.
        pkt = mk(0, 0, 0, 2, 1, 32'hCAFE_0001);
        step("east_wr",  0, 1, pkt, '0);
        step("east_req", 1, 0, '0, '0);
        check("east_hopx", 64'(data_out[55:52]), 64'd1);
        check("east_vc",   64'(data_out[63]),    64'd1);
        step("east_clr", 0, 0, '0, 5'b01000);
        step("east_gone", 1, 0, '0, '0);
        step("east_refill", 0, 0, '0, '0);

        // Local delivery into even VC.
        pkt = mk(1, 1, 1, 0, 0, 32'h1234_5678);
        step("pe_wr",  1, 1, pkt, '0);
        step("pe_req", 0, 0, '0, '0);
        check("pe_hdr", data_out, {1'b0, pkt[62:0]});
        step("pe_clr", 1, 0, '0, 5'b00001);

        // South packet.
        pkt = mk(1, 1, 1, 0, 3, 32'h0000_5555);
        step("s_wr",  0, 1, pkt, '0);
        step("s_req", 1, 0, '0, '0);
        check("s_hopy", 64'(data_out[51:48]), 64'd2);
        step("s_clr", 0, 0, '0, 5'b00010);

        // Blocked output, ignored send, wrong-direction clear.
        pkt = mk(0, 0, 0, 5, 0, 32'hB10C_B10C);
        step("blk_wr",   0, 1, pkt, '0);
        step("blk_req1", 1, 0, '0, '0);
        step("blk_send", 0, 1, mk(0, 1, 0, 1, 1, 32'hDEAD_BEEF), '0);
        step("blk_req2", 1, 0, '0, '0);
        step("blk_wrong", 0, 0, '0, 5'b00001);
        step("blk_req3", 1, 0, '0, '0);
        check("blk_still", 64'(req), 64'h08);
        step("blk_clr", 0, 0, '0, 5'b01000);
        step("blk_done", 1, 0, '0, '0);

        // Asynchronous reset while a packet is being presented.
        pkt = mk(0, 1, 0, 0, 2, 32'h0A5C_0A5C);
        step("ar_wr", 0, 1, pkt, '0);
        @(negedge clk);
        polarity = 1'b1; send_in = 1'b0; clear_in = '0;
        #1;
        check_outputs("ar_pre");
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("ar_async");
        @(negedge clk);
        reset = 1'b0;

        // Randomized traffic with mostly-correct clears.
        for (int i = 0; i < 300; i++) begin
            p   = i[0];
            pkt = {$urandom, $urandom};
            pkt[55:52] = 4'($urandom_range(0, 3));
            pkt[51:48] = 4'($urandom_range(0, 3));
            clr = ($urandom_range(0, 1) == 1) ? m_route[p ? 0 : 1] : 5'($urandom);
            step("rand", p, 1'($urandom_range(0, 1)), pkt, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
